// File: rtl/hs_unit_medge_det.sv
// hs_unit_medge_det: multi-channel synchronized, debounced edge detector with sticky flags, counters and irq
module hs_unit_medge_det #(
  parameter int                  CHANNELS    = 8,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  FILTER_LEN  = 4,
  parameter int                  CNT_W       = 8,
  parameter logic [CHANNELS-1:0] RESET_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic [CHANNELS-1:0]       signal_in,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       flag_clr,
  input  logic [CHANNELS-1:0]       cnt_clr,
  input  logic [CHANNELS-1:0]       irq_en,
  output logic [CHANNELS-1:0]       level_out,
  output logic [CHANNELS-1:0]       edge_pulse,
  output logic [CHANNELS-1:0]       edge_flag,
  output logic [CHANNELS-1:0]       edge_ovf,
  output logic [CNT_W*CHANNELS-1:0] evt_cnt,
  output logic                      irq
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FC_LAST = FW'(FILTER_LEN - 1);
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] flag_n;
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = signal_in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sq;
    // shift raw inputs through the synchronizer chain
    always_ff @(posedge clk or negedge aresetn)
      if (!aresetn) begin
        sq <= {SYNC_STAGES{RESET_VALUE}};
      end else begin
        sq[0] <= signal_in;
        for (int k = 1; k < SYNC_STAGES; k++) sq[k] <= sq[k-1];
      end
    assign s = sq[SYNC_STAGES-1];
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [FW-1:0]    fc;
    logic             lvl, pls, flg, ovf, acc, match;
    logic [CNT_W-1:0] cnt, cnt_n;
    assign acc       = (s[i] != lvl) && (fc == FC_LAST);
    assign match     = acc && (s[i] ? mode[2*i] : mode[2*i+1]);
    assign flag_n[i] = match || (flg && !flag_clr[i]);
    assign cnt_n     = cnt_clr[i] ? CNT_W'(match) : (match && !(&cnt)) ? cnt + 1'b1 : cnt;
    // debounce filter, edge match and per-channel event bookkeeping
    always_ff @(posedge clk or negedge aresetn)
      if (!aresetn) begin
        fc  <= '0;
        lvl <= RESET_VALUE[i];
        pls <= 1'b0;
        flg <= 1'b0;
        ovf <= 1'b0;
        cnt <= '0;
      end else begin
        fc  <= (s[i] == lvl || acc) ? '0 : fc + 1'b1;
        lvl <= acc ? s[i] : lvl;
        pls <= match;
        flg <= flag_n[i];
        ovf <= !flag_clr[i] && (ovf || (match && flg));
        cnt <= cnt_n;
      end
    assign level_out[i]                = lvl;
    assign edge_pulse[i]               = pls;
    assign edge_flag[i]                = flg;
    assign edge_ovf[i]                 = ovf;
    assign evt_cnt[CNT_W*i +: CNT_W]   = cnt;
  end
  // interrupt follows the next-state flags so it rises together with edge_flag
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) irq <= 1'b0;
    else irq <= |(flag_n & irq_en);
endmodule

// File: tb/tb_hs_unit_medge_det.sv
// tb_hs_unit_medge_det: directed checks of a default instance and a fast (no sync, FILTER_LEN=1, CNT_W=2) instance
module tb_hs_unit_medge_det;
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  sig0, fclr0, cclr0, ien0, lvl0, pls0, flg0, ovf0;
  logic [15:0] mode0;
  logic [63:0] cnt0;
  logic        irq0;
  logic [7:0]  sig1, fclr1, cclr1, ien1, lvl1, pls1, flg1, ovf1;
  logic [15:0] mode1, cnt1;
  logic        irq1;
  int          n_cmp = 0;
  int          n_bad = 0;
  typedef struct {
    logic [7:0]  sig;
    logic [15:0] mode;
    logic [7:0]  fclr, cclr, ien, lvl, pls, flg, ovf;
    logic [15:0] cnt;
    logic        irq;
  } vec_t;
  vec_t tbl [19];
  always #5 clk = ~clk;
  hs_unit_medge_det u0 (
    .clk(clk), .aresetn(aresetn), .signal_in(sig0), .mode(mode0), .flag_clr(fclr0),
    .cnt_clr(cclr0), .irq_en(ien0), .level_out(lvl0), .edge_pulse(pls0), .edge_flag(flg0),
    .edge_ovf(ovf0), .evt_cnt(cnt0), .irq(irq0)
  );
  hs_unit_medge_det #(.SYNC_STAGES(0), .FILTER_LEN(1), .CNT_W(2)) u1 (
    .clk(clk), .aresetn(aresetn), .signal_in(sig1), .mode(mode1), .flag_clr(fclr1),
    .cnt_clr(cclr1), .irq_en(ien1), .level_out(lvl1), .edge_pulse(pls1), .edge_flag(flg1),
    .edge_ovf(ovf1), .evt_cnt(cnt1), .irq(irq1)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // drive ch3 of u0 to v and watch the filtered acceptance, optionally clearing the flag on that edge
  task automatic u0_event(input logic v, input logic clr);
    sig0[3] = v;
    for (int n = 1; n <= 8; n++) begin
      if (n == 6) fclr0[3] = clr;
      tick();
      fclr0[3] = 1'b0;
      chk($sformatf("u0 ch3 pulse n=%0d", n), 64'(pls0[3]), 64'(n == 6));
      chk($sformatf("u0 ch3 level n=%0d", n), 64'(lvl0[3]), 64'(n >= 6 ? v : !v));
    end
  endtask
  initial begin
    tbl[0]  = '{8'h00, 16'h04E4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0};
    tbl[1]  = '{8'h0F, 16'h04E4, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h0A, 8'h0A, 8'h00, 16'h0044, 1'b0};
    tbl[2]  = '{8'h0F, 16'h04E4, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h0A, 8'h00, 16'h0044, 1'b0};
    tbl[3]  = '{8'h00, 16'h04E4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h0E, 8'h08, 16'h0094, 1'b0};
    tbl[4]  = '{8'h08, 16'h04E4, 8'h00, 8'h00, 8'h00, 8'h08, 8'h08, 8'h0E, 8'h08, 16'h00D4, 1'b0};
    tbl[5]  = '{8'h00, 16'h04E4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h0E, 8'h08, 16'h00D4, 1'b0};
    tbl[6]  = '{8'h08, 16'h04E4, 8'h00, 8'h00, 8'h00, 8'h08, 8'h08, 8'h0E, 8'h08, 16'h00D4, 1'b0};
    tbl[7]  = '{8'h00, 16'h04E4, 8'h00, 8'h08, 8'h00, 8'h00, 8'h08, 8'h0E, 8'h08, 16'h0054, 1'b0};
    tbl[8]  = '{8'h00, 16'h04E4, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 16'h0054, 1'b0};
    tbl[9]  = '{8'h02, 16'h04E4, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h06, 8'h02, 16'h0058, 1'b0};
    tbl[10] = '{8'h00, 16'h04E4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06, 8'h02, 16'h0058, 1'b0};
    tbl[11] = '{8'h02, 16'h04E4, 8'h02, 8'h00, 8'h00, 8'h02, 8'h02, 8'h06, 8'h00, 16'h005C, 1'b0};
    tbl[12] = '{8'h02, 16'h04E4, 8'h00, 8'h00, 8'h04, 8'h02, 8'h00, 8'h06, 8'h00, 16'h005C, 1'b1};
    tbl[13] = '{8'h22, 16'h04E4, 8'h00, 8'h00, 8'h04, 8'h22, 8'h20, 8'h26, 8'h00, 16'h045C, 1'b1};
    tbl[14] = '{8'h22, 16'h04E4, 8'h04, 8'h00, 8'h04, 8'h22, 8'h00, 8'h22, 8'h00, 16'h045C, 1'b0};
    tbl[15] = '{8'h22, 16'h04E4, 8'h00, 8'h00, 8'h20, 8'h22, 8'h00, 8'h22, 8'h00, 16'h045C, 1'b1};
    tbl[16] = '{8'h22, 16'h04E4, 8'h00, 8'hFF, 8'h20, 8'h22, 8'h00, 8'h22, 8'h00, 16'h0000, 1'b1};
    tbl[17] = '{8'h22, 16'hFFFF, 8'h00, 8'h00, 8'h20, 8'h22, 8'h00, 8'h22, 8'h00, 16'h0000, 1'b1};
    tbl[18] = '{8'h00, 16'hFFFF, 8'h00, 8'h00, 8'h20, 8'h00, 8'h22, 8'h22, 8'h22, 16'h0404, 1'b1};
    sig0 = 8'($urandom); mode0 = 16'($urandom); fclr0 = 8'($urandom); cclr0 = 8'($urandom); ien0 = 8'($urandom);
    sig1 = 8'($urandom); mode1 = 16'($urandom); fclr1 = 8'($urandom); cclr1 = 8'($urandom); ien1 = 8'($urandom);
    repeat (3) tick();
    chk("u0 reset level", 64'(lvl0), 64'h0);
    chk("u0 reset pulse", 64'(pls0), 64'h0);
    chk("u0 reset flag/ovf", 64'({flg0, ovf0}), 64'h0);
    chk("u0 reset cnt", cnt0, 64'h0);
    chk("u0 reset irq", 64'(irq0), 64'h0);
    chk("u1 reset all", 64'({lvl1, pls1, flg1, ovf1, cnt1, irq1}), 64'h0);
    sig0 = 8'h01; mode0 = 16'h0001; fclr0 = '0; cclr0 = '0; ien0 = '0;
    sig1 = 8'h00; mode1 = 16'h0000; fclr1 = '0; cclr1 = '0; ien1 = '0;
    aresetn = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      chk($sformatf("u0 startup ch0 pulse n=%0d", n), 64'(pls0[0]), 64'(n == 6));
      chk($sformatf("u0 startup ch0 level n=%0d", n), 64'(lvl0[0]), 64'(n >= 6));
    end
    chk("u0 startup flag", 64'(flg0), 64'h01);
    chk("u0 startup cnt", cnt0, 64'h1);
    foreach (tbl[k]) begin
      sig1 = tbl[k].sig; mode1 = tbl[k].mode; fclr1 = tbl[k].fclr; cclr1 = tbl[k].cclr; ien1 = tbl[k].ien;
      tick();
      chk($sformatf("u1 v%0d level", k), 64'(lvl1), 64'(tbl[k].lvl));
      chk($sformatf("u1 v%0d pulse", k), 64'(pls1), 64'(tbl[k].pls));
      chk($sformatf("u1 v%0d flag", k), 64'(flg1), 64'(tbl[k].flg));
      chk($sformatf("u1 v%0d ovf", k), 64'(ovf1), 64'(tbl[k].ovf));
      chk($sformatf("u1 v%0d cnt", k), 64'(cnt1), 64'(tbl[k].cnt));
      chk($sformatf("u1 v%0d irq", k), 64'(irq1), 64'(tbl[k].irq));
    end
    mode0 = 16'h00C1;
    sig0[3] = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      if (n == 4) sig0[3] = 1'b0;
      tick();
      chk($sformatf("u0 glitch pulse n=%0d", n), 64'(pls0[3]), 64'h0);
      chk($sformatf("u0 glitch level n=%0d", n), 64'(lvl0[3]), 64'h0);
    end
    u0_event(1'b1, 1'b0);
    chk("u0 ev1 cnt", 64'(cnt0[31:24]), 64'd1);
    chk("u0 ev1 flag", 64'(flg0), 64'h09);
    chk("u0 ev1 ovf", 64'(ovf0), 64'h00);
    u0_event(1'b0, 1'b0);
    u0_event(1'b1, 1'b0);
    chk("u0 ev3 flag", 64'(flg0[3]), 64'h1);
    chk("u0 ev3 ovf", 64'(ovf0[3]), 64'h1);
    chk("u0 ev3 cnt", 64'(cnt0[31:24]), 64'd3);
    u0_event(1'b0, 1'b1);
    chk("u0 ev4 flag", 64'(flg0[3]), 64'h1);
    chk("u0 ev4 ovf", 64'(ovf0[3]), 64'h0);
    chk("u0 ev4 cnt", 64'(cnt0[31:24]), 64'd4);
    ien0 = 8'h08;
    tick();
    chk("u0 irq on", 64'(irq0), 64'h1);
    ien0 = 8'h00;
    tick();
    chk("u0 irq off", 64'(irq0), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
